// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path (pattern transmitter and detector).
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Pattern length actually used: 0 or anything beyond the register width means "full width".
  function automatic int len_eff(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Request/status bundle of the serial pattern transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int REP_W = 4
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             ready;
  logic             busy;
  logic             out;
  logic             valid;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  ready, busy, out, valid, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output ready, busy, out, valid, done
  );

endinterface

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register; its MSB flop drives the serial line directly.
module seq_shift_reg #(
  parameter int   PAT_W = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] sr;

  // Reset to the fill value so the line sits at its idle level immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= {PAT_W{FILL}};
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[PAT_W-2:0], FILL};
    end
  end

  assign msb = sr[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: replays a captured pattern MSB-first, reps+1 times,
// with GAP idle cycles between repetitions.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = $clog2(PAT_W) + 1,
  parameter int   REP_W    = 4,
  parameter int   GAP      = 2,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  seq_pattern_tx_if.slave    bus
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_n;
  logic [LEN_W-1:0] bit_cnt, bit_n;
  logic [REP_W-1:0] rep_cnt, rep_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [LEN_W-1:0] len_q, len_in, last_bit;
  logic [PAT_W-1:0] pat_q, pat_in;
  logic             valid_q, done_q, done_n;
  logic             cap, sr_load, sr_shift;
  logic [PAT_W-1:0] sr_din;
  logic             line;

  // The pattern is left-aligned on capture so the shifter always starts at its MSB.
  assign len_in   = LEN_W'(len_eff(int'(bus.len), PAT_W));
  assign pat_in   = bus.pattern << (PAT_W - int'(len_in));
  assign last_bit = len_q - 1'b1;

  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    rep_n    = rep_cnt;
    gap_n    = gap_cnt;
    done_n   = 1'b0;
    cap      = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = {PAT_W{IDLE_BIT}};
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          cap     = 1'b1;
          sr_load = 1'b1;
          sr_din  = pat_in;
          bit_n   = '0;
          rep_n   = bus.reps;
          gap_n   = '0;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt == last_bit) begin
          bit_n   = '0;
          sr_load = 1'b1;
          if (rep_cnt != '0) begin
            rep_n = rep_cnt - 1'b1;
            if (GAP > 0) begin
              gap_n   = '0;
              state_n = S_GAP;
            end else begin
              sr_din = pat_q;
            end
          end else begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          bit_n    = bit_cnt + 1'b1;
          sr_shift = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          sr_load = 1'b1;
          sr_din  = pat_q;
          state_n = S_SEND;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      len_q   <= LEN_W'(PAT_W);
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      rep_cnt <= rep_n;
      gap_cnt <= gap_n;
      valid_q <= (state_n == S_SEND);
      done_q  <= done_n;
      if (cap) begin
        len_q <= len_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      pat_q <= pat_in;
    end
  end

  seq_shift_reg #(
    .PAT_W (PAT_W),
    .FILL  (IDLE_BIT)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (line)
  );

  assign bus.ready = (state == S_IDLE);
  assign bus.busy  = (state != S_IDLE);
  assign bus.out   = line;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx against a per-cycle line model built from the transfer rules.
module tb_seq_pattern_tx;

  localparam int   PAT_W = 8;
  localparam int   GAP   = 2;
  localparam logic IDLE  = 1'b0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(4), .REP_W(4)) ifc ();

  seq_pattern_tx #(
    .PAT_W    (PAT_W),
    .LEN_W    (4),
    .REP_W    (4),
    .GAP      (GAP),
    .IDLE_BIT (IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Expected {valid,out} for every busy cycle following the accepting edge.
  task automatic build_expect(input logic [7:0] p, input int l, input int r, output logic [1:0] q[$]);
    int le;
    le = (l == 0 || l > PAT_W) ? PAT_W : l;
    q = {};
    for (int t = 0; t <= r; t++) begin
      for (int k = le - 1; k >= 0; k--) q.push_back({1'b1, p[k]});
      if (t < r) for (int g = 0; g < GAP; g++) q.push_back({1'b0, IDLE});
    end
  endtask

  task automatic drive_start(input logic [7:0] p, input int l, input int r);
    @(negedge clk);
    ifc.start = 1'b1; ifc.pattern = p; ifc.len = 4'(l); ifc.reps = 4'(r);
    @(posedge clk); #1;
    ifc.start = 1'b0; ifc.pattern = 8'($urandom); ifc.len = 4'($urandom); ifc.reps = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; ifc.start = 1'b0; ifc.pattern = '0; ifc.len = '0; ifc.reps = '0;
    @(negedge clk);
    checks++;
    if ({ifc.ready, ifc.busy, ifc.valid, ifc.done, ifc.out} !== {1'b1, 1'b0, 1'b0, 1'b0, IDLE}) begin
      errors++; $display("FAIL reset_state: rdy,busy,vld,done,out=%b%b%b%b%b expected 1000%b",
        ifc.ready, ifc.busy, ifc.valid, ifc.done, ifc.out, IDLE);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.ready, ifc.busy, ifc.valid, ifc.done} !== 4'b1000) begin
      errors++; $display("FAIL after_reset: rdy,busy,vld,done=%b%b%b%b expected 1000",
        ifc.ready, ifc.busy, ifc.valid, ifc.done);
    end
  endtask

  task automatic test_single();
    logic [1:0] q[$];
    build_expect(8'b1011, 4, 0, q);
    drive_start(8'b1011, 4, 0);
    foreach (q[i]) begin
      @(negedge clk); checks++;
      if ({ifc.valid, ifc.out} !== q[i] || ifc.busy !== 1'b1 || ifc.ready !== 1'b0 || ifc.done !== 1'b0) begin
        errors++; $display("FAIL single[%0d]: vld,out,busy,done=%b%b%b%b expected %b%b10",
          i, ifc.valid, ifc.out, ifc.busy, ifc.done, q[i][1], q[i][0]);
      end
    end
    @(negedge clk); checks++;
    if ({ifc.done, ifc.ready, ifc.busy, ifc.valid, ifc.out} !== {4'b1100, IDLE}) begin
      errors++; $display("FAIL single_done: done,rdy,busy,vld,out=%b%b%b%b%b expected 1100%b",
        ifc.done, ifc.ready, ifc.busy, ifc.valid, ifc.out, IDLE);
    end
    @(negedge clk); checks++;
    if (ifc.done !== 1'b0 || ifc.ready !== 1'b1) begin
      errors++; $display("FAIL single_done_pulse: done,rdy=%b%b expected 01", ifc.done, ifc.ready);
    end
  endtask

  task automatic test_repeat_gap();
    logic [1:0] q[$];
    int busy_cycles = 0;
    build_expect(8'b110, 3, 2, q);
    drive_start(8'b110, 3, 2);
    foreach (q[i]) begin
      @(negedge clk); checks++;
      if (ifc.busy === 1'b1) busy_cycles++;
      if ({ifc.valid, ifc.out} !== q[i] || ifc.done !== 1'b0) begin
        errors++; $display("FAIL repeat[%0d]: vld,out,done=%b%b%b expected %b%b0",
          i, ifc.valid, ifc.out, ifc.done, q[i][1], q[i][0]);
      end
    end
    @(negedge clk); checks++;
    if (ifc.busy === 1'b1) busy_cycles++;
    if (ifc.done !== 1'b1 || busy_cycles != 13) begin
      errors++; $display("FAIL repeat_done: done=%b busy_cycles=%0d expected done=1 busy_cycles=13",
        ifc.done, busy_cycles);
    end
  endtask

  // Start held high through the whole first transfer: only the done-cycle sample may accept it.
  task automatic test_back_to_back();
    logic [1:0] q1[$], q2[$];
    build_expect(8'b1101, 4, 1, q1);
    build_expect(8'b10, 2, 0, q2);
    @(negedge clk);
    ifc.start = 1'b1; ifc.pattern = 8'b1101; ifc.len = 4'd4; ifc.reps = 4'd1;
    @(posedge clk); #1;
    ifc.pattern = 8'b10; ifc.len = 4'd2; ifc.reps = 4'd0;
    foreach (q1[i]) begin
      @(negedge clk); checks++;
      if ({ifc.valid, ifc.out} !== q1[i] || ifc.busy !== 1'b1) begin
        errors++; $display("FAIL b2b_first[%0d]: vld,out,busy=%b%b%b expected %b%b1",
          i, ifc.valid, ifc.out, ifc.busy, q1[i][1], q1[i][0]);
      end
    end
    @(negedge clk); checks++;
    if (ifc.done !== 1'b1 || ifc.ready !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done,rdy=%b%b expected 11", ifc.done, ifc.ready);
    end
    @(posedge clk); #1;
    ifc.start = 1'b0;
    foreach (q2[i]) begin
      @(negedge clk); checks++;
      if ({ifc.valid, ifc.out} !== q2[i] || ifc.busy !== 1'b1) begin
        errors++; $display("FAIL b2b_second[%0d]: vld,out,busy=%b%b%b expected %b%b1",
          i, ifc.valid, ifc.out, ifc.busy, q2[i][1], q2[i][0]);
      end
    end
    @(negedge clk); checks++;
    if (ifc.done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_done: done=%b expected 1", ifc.done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); checks++;
      if ({ifc.busy, ifc.valid, ifc.done} !== 3'b000) begin
        errors++; $display("FAIL b2b_no_reaccept[%0d]: busy,vld,done=%b%b%b expected 000",
          i, ifc.busy, ifc.valid, ifc.done);
      end
    end
  endtask

  // Covers len edge cases, saturating repeat count and random transfers.
  task automatic test_lengths_random();
    logic [1:0] q[$];
    logic [7:0] p;
    int l, r, vcount;
    for (int n = 0; n < 24; n++) begin
      case (n)
        0: begin p = 8'hA5; l = 0;  r = 0;  end
        1: begin p = 8'h01; l = 1;  r = 0;  end
        2: begin p = 8'h5A; l = 12; r = 0;  end
        3: begin p = 8'h01; l = 1;  r = 15; end
        default: begin p = 8'($urandom); l = $urandom_range(0, 15); r = $urandom_range(0, 3); end
      endcase
      build_expect(p, l, r, q);
      drive_start(p, l, r);
      vcount = 0;
      foreach (q[i]) begin
        @(negedge clk); checks++;
        if (ifc.valid === 1'b1) vcount++;
        if ({ifc.valid, ifc.out} !== q[i] || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
          errors++; $display("FAIL xfer%0d[%0d] p=%h len=%0d reps=%0d: vld,out,busy,done=%b%b%b%b expected %b%b10",
            n, i, p, l, r, ifc.valid, ifc.out, ifc.busy, ifc.done, q[i][1], q[i][0]);
        end
      end
      @(negedge clk); checks++;
      if ({ifc.done, ifc.ready, ifc.valid, ifc.out} !== {3'b110, IDLE}) begin
        errors++; $display("FAIL xfer%0d_done: done,rdy,vld,out=%b%b%b%b expected 110%b",
          n, ifc.done, ifc.ready, ifc.valid, ifc.out, IDLE);
      end
      if (n == 3) begin
        checks++;
        if (vcount != 16) begin
          errors++; $display("FAIL max_reps_bits: got %0d bits expected 16", vcount);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] q[$];
    drive_start(8'hFF, 8, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.valid !== 1'b1 || ifc.out !== 1'b1) begin
      errors++; $display("FAIL mid_reset_pre: vld,out=%b%b expected 11", ifc.valid, ifc.out);
    end
    #2 reset = 1'b1;
    #1; checks++;
    if ({ifc.out, ifc.valid, ifc.busy, ifc.ready, ifc.done} !== {IDLE, 4'b0010}) begin
      errors++; $display("FAIL mid_reset_async: out,vld,busy,rdy,done=%b%b%b%b%b expected %b0010",
        ifc.out, ifc.valid, ifc.busy, ifc.ready, ifc.done, IDLE);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); checks++;
      if ({ifc.done, ifc.valid, ifc.busy} !== 3'b000) begin
        errors++; $display("FAIL mid_reset_quiet[%0d]: done,vld,busy=%b%b%b expected 000",
          i, ifc.done, ifc.valid, ifc.busy);
      end
    end
    build_expect(8'h3C, 6, 0, q);
    drive_start(8'h3C, 6, 0);
    foreach (q[i]) begin
      @(negedge clk); checks++;
      if ({ifc.valid, ifc.out} !== q[i]) begin
        errors++; $display("FAIL post_reset[%0d]: vld,out=%b%b expected %b%b",
          i, ifc.valid, ifc.out, q[i][1], q[i][0]);
      end
    end
    @(negedge clk); checks++;
    if (ifc.done !== 1'b1) begin
      errors++; $display("FAIL post_reset_done: done=%b expected 1", ifc.done);
    end
  endtask

  // Scans the line for the 1011 target a downstream detector would look for.
  task automatic test_loopback();
    logic [1:0] q[$];
    logic       seen[$];
    int         exp_hits[$], got_hits[$];
    build_expect(8'b1011_1011, 8, 1, q);
    drive_start(8'b1011_1011, 8, 1);
    foreach (q[i]) begin
      @(negedge clk);
      seen.push_back(ifc.out);
    end
    for (int i = 3; i < q.size(); i++) begin
      if (q[i-3][0] && !q[i-2][0] && q[i-1][0] && q[i][0]) exp_hits.push_back(i);
      if (seen[i-3] && !seen[i-2] && seen[i-1] && seen[i]) got_hits.push_back(i);
    end
    checks++;
    if (got_hits.size() != exp_hits.size() || exp_hits.size() != 4) begin
      errors++; $display("FAIL loopback_count: got %0d hits expected %0d (model) / 4",
        got_hits.size(), exp_hits.size());
    end else begin
      foreach (exp_hits[i]) begin
        checks++;
        if (got_hits[i] != exp_hits[i]) begin
          errors++; $display("FAIL loopback_cycle[%0d]: got %0d expected %0d", i, got_hits[i], exp_hits[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_lengths_random();
    test_mid_reset();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives a single-bit line with a programmed bit pattern, MSB-first, one bit per clock. It is the source end of the serial sequence path: its `out` feeds the `in` of the sequence detector, both in system use and as a self-checking stimulus generator. A ready/start handshake accepts a pattern, its length and a repeat count. The pattern is then replayed the requested number of times, with a programmable idle gap between repetitions.

## Interface
- `PAT_W`, 8: maximum pattern length in bits.
- `LEN_W`, $clog2(PAT_W)+1: width of `len`.
- `REP_W`, 4: width of `reps`.
- `GAP`, 2: idle cycles inserted between repetitions; 0 means back-to-back.
- `IDLE_BIT`, 0: value driven on `out` whenever no pattern bit is being sent.

- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; accepted on the edge where `start && ready` is true.
- `pattern`, input, PAT_W: bits to send; `pattern[len-1]` is sent first.
- `len`, input, LEN_W: pattern length, 1..PAT_W. A value of 0, or any value above PAT_W, is treated as PAT_W.
- `reps`, input, REP_W: repeat count; total transmissions = `reps` + 1.
- `ready`, output, 1: high when idle, i.e. `!busy`.
- `busy`, output, 1: high from the cycle after acceptance until the final bit has been sent.
- `out`, output, 1: serial line, registered.
- `valid`, output, 1: high when `out` carries a pattern bit.
- `done`, output, 1: one-cycle pulse after the final bit of the final repetition.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - Outputs: `out`=IDLE_BIT, `valid`=0.
  - On `start && ready`: capture `pattern`, the effective `len` and `reps`; go to SEND.
  - `start` while busy is ignored. No queueing and no error flag.
- SEND:
  - Shift out captured bits MSB-first (from bit `len`-1 down to 0), with `valid`=1.
  - Bit counter runs 0..len-1. The repetition counter counts down from `reps`.
  - After the last bit, if repetitions remain: go to GAP if GAP>0, otherwise re-enter SEND at bit `len`-1 with no bubble.
  - After the last bit with no repetitions left: go to IDLE and pulse `done`.
- GAP:
  - Outputs: `out`=IDLE_BIT, `valid`=0, `busy` stays 1.
  - After exactly GAP cycles, return to SEND.
- Input changes after acceptance have no effect. Captured values are held until the transfer ends.
- Reset, asynchronous and allowed at any time, including mid-pattern:
  - State goes to IDLE; all counters clear.
  - Outputs: `out`=IDLE_BIT, `valid`=0, `busy`=0, `ready`=1, `done`=0.
  - The partial pattern is abandoned and there is no `done` pulse.

## Timing
- Define edge E0 as the edge that accepts `start`.
- Bit k (k=0..len-1) is on `out` during the cycle after edge E0+k. First-bit latency is 1 cycle.
- One repetition occupies `len` cycles. Each gap occupies GAP cycles.
- Total busy cycles = (reps+1)·len + reps·GAP.
- `done`=1 and `ready`=1 together, in the single cycle immediately after the final bit.
- A `start` sampled during that `done` cycle is accepted; its first bit follows one cycle later. This gives a minimum 1-cycle idle separation between transfers.
- Arithmetic and counter width rules:
  - The bit counter is LEN_W wide.
  - The repetition counter is REP_W wide and saturates at 0. With `reps`=2^REP_W−1, exactly 2^REP_W transmissions occur; there is no wrap.
  - The gap counter is $clog2(GAP+1) wide.

## Structure
- Shared package `seq_pkg`, also used by the detector:
  - state enum {IDLE, SEND, GAP}
  - IDLE_BIT default
  - a `len_eff` function (0 or >PAT_W maps to PAT_W)
- One sub-module, `seq_shift_reg`: PAT_W-bit loadable left-shift register with `load`, `shift`, and `msb` output. It is reloaded from the captured pattern at the start of each repetition.
- The FSM, the three counters and the output registers live in the top module.

## Test plan
- Single transfer: reset for 1 cycle, then `start` with pattern=4'b1011, len=4, reps=0.
  - Response: `out`=1,0,1,1 with `valid`=1 on cycles E0+1..E0+4; `done` at E0+5; `ready` restored at E0+5.
- Repeat with gap (GAP=2): pattern=3'b110, len=3, reps=2.
  - Response: 110, idle, idle, 110, idle, idle, 110; then `done`. Total busy = 13 cycles.
- Back-to-back transfer:
  - Assert `start` (pattern=2'b10, len=2) during the `done` cycle of the previous transfer.
  - Response: first bit 1 on the next cycle. A `start` held during `busy` is never double-accepted.
- Length edge cases (PAT_W=8):
  - len=0 with pattern=8'hA5: sends 10100101.
  - len=1 with pattern bit0=1: sends a single 1, then `done`.
- Mid-pattern reset: assert `reset` asynchronously during bit 2 of 8'hFF.
  - Response: `out`=IDLE_BIT and `valid`=0 immediately; no `done`; next `start` accepted normally.
- Detector loopback: drive `out` into the sequence detector with a pattern containing its target sequence.
  - Response: detector `out` pulses exactly once per embedded occurrence, at the expected cycle.
